// File: rtl/motor_cmd_scheduler_if.sv
// Command handshake between the navigation logic (master) and the motor
// command scheduler (slave): two 5-bit target codes under valid/ready.
interface motor_cmd_scheduler_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [4:0] CMD_MC1;
    logic [4:0] CMD_MC2;

    modport master (
        output CMD_VALID,
        output CMD_MC1,
        output CMD_MC2,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_MC1,
        input  CMD_MC2,
        output CMD_READY
    );
endinterface

// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler: accepts MC1/MC2 speed-code commands, applies them
// on frame boundaries, slew-limits both channels once per frame, and forces
// neutral on emergency stop or when commands stop arriving.
module motor_cmd_scheduler #(
    parameter int unsigned FRAME_CYCLES   = 1100000,
    parameter logic [4:0]  NEUTRAL        = 5'd16,
    parameter int unsigned STEP           = 2,
    parameter logic [4:0]  MAX_CODE       = 5'd23,
    parameter int unsigned TIMEOUT_FRAMES = 10
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    motor_cmd_scheduler_if.slave        cmd,
    input  logic                        ESTOP,
    output logic [4:0]                  MC1,
    output logic [4:0]                  MC2,
    output logic                        FRAME_TICK,
    output logic [1:0]                  STATE,
    output logic                        FAULT
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FAILSAFE = 2'd2,
        ST_STOP     = 2'd3
    } state_t;

    localparam int                  CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam int                  WD_W     = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [WD_W-1:0]     WD_MAX   = WD_W'(TIMEOUT_FRAMES);
    localparam logic signed [5:0]   STEP_S   = 6'(STEP);
    localparam logic [4:0]          STEP_5   = 5'(STEP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [4:0]       mc1_q, mc1_d, mc2_q, mc2_d;
    logic [4:0]       tgt1_q, tgt1_d, tgt2_q, tgt2_d;
    logic [4:0]       pend1_q, pend1_d, pend2_q, pend2_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic             cmd_ready;
    logic             xfer;
    logic             apply;
    logic             timeout;
    logic [WD_W-1:0]  wd_inc;

    // Commands above the legal range are pinned to the highest legal code.
    function automatic logic [4:0] clamp_code(input logic [4:0] code);
        clamp_code = (code > MAX_CODE) ? MAX_CODE : code;
    endfunction

    // One slew step: jump to the target when within STEP, else move by STEP.
    // Both operands are legal codes, so the result stays within 0..MAX_CODE.
    function automatic logic [4:0] ramp_code(input logic [4:0] cur, input logic [4:0] tgt);
        logic signed [5:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)
            ramp_code = cur + STEP_5;
        else if (diff < -STEP_S)
            ramp_code = cur - STEP_5;
        else
            ramp_code = tgt;
    endfunction

    assign cmd_ready     = !pend_valid_q && (state_q != ST_STOP) && !ESTOP;
    assign cmd.CMD_READY = cmd_ready;
    assign xfer          = cmd.CMD_VALID && cmd_ready;
    // Ready is low whenever a command is pending, so apply never meets a transfer.
    assign apply         = tick_q && pend_valid_q;
    assign wd_inc        = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    // A transfer on the tick cycle clears the watchdog, so it cannot time out.
    assign timeout       = tick_q && (state_q == ST_RUN) && !apply && !xfer && (wd_inc == WD_MAX);

    // Free-running frame counter; the tick flop is high while the count is at its last value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == CNT_LAST);
    end

    // Mode next-state: ESTOP overrides everything; otherwise transitions happen on frame ticks.
    always_comb begin
        state_d = state_q;
        if (ESTOP) begin
            state_d = ST_STOP;
        end else begin
            case (state_q)
                ST_IDLE:     if (apply)   state_d = ST_RUN;
                ST_RUN:      if (timeout) state_d = ST_FAILSAFE;
                ST_FAILSAFE: if (apply)   state_d = ST_RUN;
                ST_STOP:     if (tick_q)  state_d = ST_IDLE;
                default:                  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: command capture, per-frame ramp, target apply, neutral forcing and watchdog.
    always_comb begin
        mc1_d        = mc1_q;
        mc2_d        = mc2_q;
        tgt1_d       = tgt1_q;
        tgt2_d       = tgt2_q;
        pend1_d      = pend1_q;
        pend2_d      = pend2_q;
        pend_valid_d = pend_valid_q;
        wd_d         = wd_q;

        if (ESTOP) begin
            mc1_d        = NEUTRAL;
            mc2_d        = NEUTRAL;
            tgt1_d       = NEUTRAL;
            tgt2_d       = NEUTRAL;
            pend_valid_d = 1'b0;
            wd_d         = '0;
        end else begin
            if (xfer) begin
                pend1_d      = clamp_code(cmd.CMD_MC1);
                pend2_d      = clamp_code(cmd.CMD_MC2);
                pend_valid_d = 1'b1;
            end
            // Ramp uses the targets in force before this tick's apply.
            if (tick_q && (state_q != ST_STOP)) begin
                mc1_d = ramp_code(mc1_q, tgt1_q);
                mc2_d = ramp_code(mc2_q, tgt2_q);
            end
            if (apply) begin
                tgt1_d       = pend1_q;
                tgt2_d       = pend2_q;
                pend_valid_d = 1'b0;
            end
            if (timeout) begin
                tgt1_d = NEUTRAL;
                tgt2_d = NEUTRAL;
            end
            if (xfer)
                wd_d = '0;
            else if (tick_q)
                wd_d = wd_inc;
        end
    end

    // State register: synchronous active-low reset, otherwise load next state.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            mc1_q        <= NEUTRAL;
            mc2_q        <= NEUTRAL;
            tgt1_q       <= NEUTRAL;
            tgt2_q       <= NEUTRAL;
            pend1_q      <= NEUTRAL;
            pend2_q      <= NEUTRAL;
            pend_valid_q <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            mc1_q        <= mc1_d;
            mc2_q        <= mc2_d;
            tgt1_q       <= tgt1_d;
            tgt2_q       <= tgt2_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            pend_valid_q <= pend_valid_d;
            wd_q         <= wd_d;
        end
    end

    assign MC1        = mc1_q;
    assign MC2        = mc2_q;
    assign FRAME_TICK = tick_q;
    assign STATE      = state_q;
    assign FAULT      = (state_q == ST_FAILSAFE) || (state_q == ST_STOP);

endmodule

// File: doc/motor_cmd_scheduler.md
Name: motor_cmd_scheduler

Overview:
- Sits between the navigation logic and the dual-channel motor-controller pulse generator.
- Accepts MC1/MC2 speed-code commands over a valid/ready handshake and applies them only on frame boundaries.
- Slew-limits each channel toward its target, once per frame.
- Forces both channels to neutral on emergency stop or on loss of commands (watchdog).

Parameters:
- FRAME_CYCLES, 1100000: clock cycles per output frame (11 ms at 100 MHz); must be ≥ 4.
- NEUTRAL, 16: 5-bit code meaning motor stopped.
- STEP, 2: maximum change per channel per frame; must be ≥ 1.
- MAX_CODE, 23: highest legal speed code; larger commands are clamped to it.
- TIMEOUT_FRAMES, 10: frames without an accepted command before failsafe; must be ≥ 1.

Ports:
- CLK  input  1  system clock
- RST_N  input  1  synchronous active-low reset
- CMD_VALID  input  1  command present
- CMD_READY  output  1  block can accept a command this cycle
- CMD_MC1  input  5  target code, channel 1
- CMD_MC2  input  5  target code, channel 2
- ESTOP  input  1  emergency stop, level-sensitive
- MC1  output  5  current code to pulse generator, channel 1
- MC2  output  5  current code to pulse generator, channel 2
- FRAME_TICK  output  1  one-cycle strobe at end of each frame
- STATE  output  2  0=IDLE, 1=RUN, 2=FAILSAFE, 3=STOP
- FAULT  output  1  high in FAILSAFE or STOP

Behaviour:
- Interface: one clock, CLK. Reset RST_N is synchronous and active-low.
- Reset values (sampled on the CLK edge with RST_N=0): MC1=MC2=NEUTRAL, targets=NEUTRAL, frame counter=0, watchdog=0, pend_valid=0, STATE=IDLE, FAULT=0, FRAME_TICK=0. Reset mid-frame or mid-ramp aborts immediately; no ramp to neutral.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1, then wraps to 0.
  - FRAME_TICK is registered; it is high for exactly the cycle in which the counter equals FRAME_CYCLES-1.
- Handshake:
  - CMD_READY = !pend_valid && STATE!=STOP && !ESTOP (combinational).
  - A transfer occurs when CMD_VALID && CMD_READY. It loads the pending register with both codes, each clamped to MAX_CODE, sets pend_valid, and clears the watchdog.
  - CMD_VALID may drop without a transfer.
- Apply on tick: when FRAME_TICK is high and pend_valid=1, targets <= pending and pend_valid <= 0. CMD_READY is low that cycle, so accept and apply never collide.
- Ramp: on each FRAME_TICK (states IDLE, RUN, FAILSAFE), each channel updates independently:
  - If |target - current| ≤ STEP, current <= target.
  - Otherwise current moves by STEP toward target.
  - The ramp uses the targets in effect before that tick's apply, so a new target first moves the output on the following tick. Total latency from accept to first output change is 1–2 frames.
- Watchdog:
  - Increments on each FRAME_TICK, saturating at TIMEOUT_FRAMES.
  - Clears on any transfer (a transfer wins over a same-cycle increment).
- State transitions:
  - IDLE -> RUN: on a tick that applies a pending command.
  - RUN -> FAILSAFE: on a tick where the watchdog reaches TIMEOUT_FRAMES. Targets <= NEUTRAL and the outputs ramp down.
  - FAILSAFE -> RUN: on a tick that applies a pending command.
  - Any state -> STOP: when ESTOP=1, on the next edge. MC1/MC2 and targets <= NEUTRAL immediately (no ramp), pend_valid <= 0, watchdog <= 0.
  - STOP -> IDLE: on the first FRAME_TICK with ESTOP=0.
  - ESTOP has priority over tick, apply and timeout in the same cycle.
- Arithmetic: differences are computed 6-bit signed; outputs never exceed MAX_CODE and never underflow below 0.

Test Plan (FRAME_CYCLES=100, STEP=2, NEUTRAL=16, MAX_CODE=23, TIMEOUT_FRAMES=3):
- Reset then idle: MC1=MC2=16, STATE=0, CMD_READY=1, FRAME_TICK every 100 cycles at count 99.
- Command 22/10 accepted at cycle 20:
  - CMD_READY stays 0 until the tick at cycle 99, then returns to 1.
  - STATE=1.
  - MC1 steps 16→18→20→22 and MC2 steps 16→14→12→10 on ticks 2, 3 and 4.
- Command 31/0: clamped; MC1 ramps to 23 with a final step of 1; MC2 ramps down to 0 without wrapping.
- No commands after RUN: third tick without a transfer -> STATE=2, FAULT=1, outputs ramp to 16; a new command -> STATE=1, FAULT=0.
- ESTOP pulse while MC1=22 mid-frame:
  - Next edge: MC1=MC2=16, STATE=3, CMD_READY=0.
  - After ESTOP drops, STATE=0 at the next tick.
- RST_N=0 mid-ramp with a pending command: all outputs return to reset values on the next edge; the pending command is discarded.
